// File: rtl/bus_arbiter_pkg.sv
// Shared types for the bus arbiter: bus transfer encodings, arbiter FSM states
// and the default requester count.
// Latency: n/a (types only).
// Backpressure: n/a.
package bus_arbiter_pkg;

  localparam int ARB_N_REQ = 2;

  // AHB-style transfer kind driven on bus_trans.
  typedef enum logic [1:0] {
    TRANS_IDLE   = 2'b00,
    TRANS_BUSY   = 2'b01,
    TRANS_NONSEQ = 2'b10,
    TRANS_SEQ    = 2'b11
  } transfer_kind;

  // Slave response returned with the data phase.
  typedef enum logic {
    RESP_OKAY  = 1'b0,
    RESP_ERROR = 1'b1
  } transfer_response;

  typedef enum logic [1:0] {
    ARB_IDLE,
    ARB_ADDR,
    ARB_DATA
  } arb_state;

endpackage

// File: rtl/bus_arbiter_if.sv
// Requester-side and bus-side signals of the bus arbiter in one bundle.
// Latency: n/a (wiring only).
// Backpressure: requesters hold req_valid until req_done; the bus stalls via bus_ready.
// Ports (modport master = the arbiter, modport slave = requesters plus bus controller):
//   req_valid/req_write/req_addr/req_wdata  per-requester request, slice i = [32*i+31:32*i]
//   req_grant/req_done/req_rdata/req_resp   grant, completion pulse and captured result
//   bus_trans/bus_write/bus_address/bus_write_data  address and data phase to the bus
//   bus_read_data/bus_ready/bus_response            data-phase return from the bus
interface bus_arbiter_if import bus_arbiter_pkg::*; #(
  parameter int N_REQ = ARB_N_REQ
);

  logic [N_REQ-1:0]    req_valid;
  logic [N_REQ-1:0]    req_write;
  logic [N_REQ*32-1:0] req_addr;
  logic [N_REQ*32-1:0] req_wdata;
  logic [N_REQ-1:0]    req_grant;
  logic [N_REQ-1:0]    req_done;
  logic [31:0]         req_rdata;
  logic                req_resp;

  logic [1:0]          bus_trans;
  logic                bus_write;
  logic [31:0]         bus_address;
  logic [31:0]         bus_write_data;
  logic [31:0]         bus_read_data;
  logic                bus_ready;
  logic                bus_response;

  modport master (
    input  req_valid, req_write, req_addr, req_wdata,
    input  bus_read_data, bus_ready, bus_response,
    output req_grant, req_done, req_rdata, req_resp,
    output bus_trans, bus_write, bus_address, bus_write_data
  );

  modport slave (
    output req_valid, req_write, req_addr, req_wdata,
    output bus_read_data, bus_ready, bus_response,
    input  req_grant, req_done, req_rdata, req_resp,
    input  bus_trans, bus_write, bus_address, bus_write_data
  );

endinterface

// File: rtl/bus_arbiter_rr_picker.sv
// Round-robin winner select: first set request bit after i_last_owner, wrapping.
// Latency: combinational.
// Backpressure: none; o_valid is low when no request is pending.
// Ports: i_req (request vector), i_last_owner (previous owner index),
//        o_winner (chosen index), o_valid (any request present).
module rr_picker import bus_arbiter_pkg::*; #(
  parameter int N_REQ = ARB_N_REQ,
  parameter int IDX_W = $clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] i_req,
  input  logic [IDX_W-1:0] i_last_owner,
  output logic [IDX_W-1:0] o_winner,
  output logic             o_valid
);

  logic [IDX_W-1:0] w_cand;

  // Scan offsets 1..N_REQ so the previous owner is considered last.
  always_comb begin
    o_winner = '0;
    o_valid  = 1'b0;
    w_cand   = '0;
    for (int k = 1; k <= N_REQ; k++) begin
      w_cand = IDX_W'((int'(i_last_owner) + k) % N_REQ);
      if (!o_valid && i_req[w_cand]) begin
        o_valid  = 1'b1;
        o_winner = w_cand;
      end
    end
  end

endmodule

// File: rtl/bus_arbiter.sv
// Round-robin arbiter sharing one AHB-style master port; one single transfer per grant.
// Latency: request seen in IDLE -> req_done 3 cycles later, +1 per bus wait state.
// Backpressure: data phase stalls on bus_ready; requesters hold req_valid until req_done.
// Ports: clk, rst (synchronous, active-high), bif (bus_arbiter_if.master, see interface).
// Optional build macro BUS_ARB_TIMEOUT_EN adds a data-phase watchdog of TIMEOUT_CYCLES.
module bus_arbiter import bus_arbiter_pkg::*; #(
  parameter int N_REQ          = ARB_N_REQ,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic          clk,
  input  logic          rst,
  bus_arbiter_if.master bif
);

  localparam int IDX_W = $clog2(N_REQ);

  arb_state         r_state;
  arb_state         w_state_nxt;
  logic [IDX_W-1:0] r_owner;
  logic [IDX_W-1:0] r_last_owner;
  logic             r_write;
  logic [31:0]      r_addr;
  logic [31:0]      r_wdata;
  logic [31:0]      r_rdata;
  transfer_response r_resp;
  logic [N_REQ-1:0] r_grant;
  logic [N_REQ-1:0] r_done;

  logic [IDX_W-1:0] w_pick_idx;
  logic             w_pick_vld;
  logic             w_start;
  logic             w_finish;
  logic             w_timeout;
  logic [31:0]      w_req_addr  [N_REQ];
  logic [31:0]      w_req_wdata [N_REQ];

  // Unpack the flat per-requester buses so the owner can be indexed directly.
  for (genvar g = 0; g < N_REQ; g++) begin : g_slice
    assign w_req_addr[g]  = bif.req_addr[32*g +: 32];
    assign w_req_wdata[g] = bif.req_wdata[32*g +: 32];
  end

  rr_picker #(
    .N_REQ (N_REQ),
    .IDX_W (IDX_W)
  ) u_picker (
    .i_req        (bif.req_valid),
    .i_last_owner (r_last_owner),
    .o_winner     (w_pick_idx),
    .o_valid      (w_pick_vld)
  );

`ifdef BUS_ARB_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [CNT_W-1:0] r_wait_cnt;
  logic [CNT_W-1:0] w_wait_cnt_inc;

  assign w_wait_cnt_inc = r_wait_cnt + 1'b1;
  // Fires on the wait cycle that would bring the count to the limit; a ready
  // on that same cycle takes precedence in the completion logic.
  assign w_timeout = (r_state == ARB_DATA) && !bif.bus_ready &&
                     (w_wait_cnt_inc == CNT_W'(TIMEOUT_CYCLES));

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wait_cnt <= '0;
    end else if (r_state == ARB_ADDR) begin
      r_wait_cnt <= '0;
    end else if (r_state == ARB_DATA && !bif.bus_ready) begin
      r_wait_cnt <= w_wait_cnt_inc;
    end
  end
`else
  // Without the watchdog the data phase waits for bus_ready indefinitely;
  // TIMEOUT_CYCLES has no effect in this build.
  assign w_timeout = 1'b0;
  if (TIMEOUT_CYCLES < 1) begin : g_no_watchdog
  end
`endif

  // Next-state logic.
  always_comb begin
    w_state_nxt = r_state;
    w_start     = 1'b0;
    w_finish    = 1'b0;
    case (r_state)
      ARB_IDLE: begin
        if (w_pick_vld) begin
          w_start     = 1'b1;
          w_state_nxt = ARB_ADDR;
        end
      end
      ARB_ADDR: begin
        w_state_nxt = ARB_DATA;
      end
      ARB_DATA: begin
        if (bif.bus_ready || w_timeout) begin
          w_finish    = 1'b1;
          w_state_nxt = ARB_IDLE;
        end
      end
      default: begin
        w_state_nxt = ARB_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ARB_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Transfer context, grant and completion registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_owner      <= '0;
      r_last_owner <= IDX_W'(N_REQ - 1);
      r_write      <= 1'b0;
      r_addr       <= '0;
      r_wdata      <= '0;
      r_rdata      <= '0;
      r_resp       <= RESP_OKAY;
      r_grant      <= '0;
      r_done       <= '0;
    end else begin
      r_done <= '0;
      if (w_start) begin
        // Request fields are sampled once here; later changes wait for the next IDLE.
        r_owner <= w_pick_idx;
        r_write <= bif.req_write[w_pick_idx];
        r_addr  <= w_req_addr[w_pick_idx];
        r_wdata <= w_req_wdata[w_pick_idx];
        r_grant <= N_REQ'(1) << w_pick_idx;
      end
      if (w_finish) begin
        r_grant      <= '0;
        r_done       <= N_REQ'(1) << r_owner;
        r_last_owner <= r_owner;
        if (bif.bus_ready) begin
          if (!r_write) begin
            r_rdata <= bif.bus_read_data;
          end
          r_resp <= transfer_response'(bif.bus_response);
        end else begin
          r_rdata <= '0;
          r_resp  <= RESP_ERROR;
        end
      end
    end
  end

  assign bif.req_grant      = r_grant;
  assign bif.req_done       = r_done;
  assign bif.req_rdata      = r_rdata;
  assign bif.req_resp       = r_resp;
  assign bif.bus_trans      = (r_state == ARB_ADDR) ? TRANS_NONSEQ : TRANS_IDLE;
  assign bif.bus_write      = r_write;
  assign bif.bus_address    = r_addr;
  assign bif.bus_write_data = r_wdata;

endmodule

// File: tb/tb_bus_arbiter.sv
// Self-checking bench for bus_arbiter: per-scenario tasks plus a completion scoreboard.
// Latency: n/a.
// Backpressure: bus_ready is driven per scenario to insert wait states.
`timescale 1ns/1ps
module tb_bus_arbiter;
  import bus_arbiter_pkg::*;

  localparam int N = 3;
`ifdef BUS_ARB_TIMEOUT_EN
  localparam int TO    = 4;
  localparam int WAITS = 3;
`else
  localparam int TO    = 64;
  localparam int WAITS = 5;
`endif
  localparam int LIM = 100;

  typedef struct {
    int          owner;
    logic [31:0] rdata;
    logic        resp;
  } exp_t;

  exp_t        exp_q[$];
  int          checks = 0;
  int          errors = 0;
  logic [31:0] model_rdata = '0;
  logic        clk = 1'b0;
  logic        rst = 1'b1;

  always #5 clk = ~clk;

  bus_arbiter_if #(.N_REQ(N)) bif ();

  bus_arbiter #(
    .N_REQ          (N),
    .TIMEOUT_CYCLES (TO)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bif (bif)
  );

  // Scoreboard: every done pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin : sb
    exp_t        e;
    logic [N-1:0] want;
    if (bif.req_done != '0) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL sb_unexpected_done done=%b expected no completion", bif.req_done);
      end else begin
        e    = exp_q.pop_front();
        want = N'(1) << e.owner;
        if (bif.req_done !== want) begin
          errors++;
          $display("FAIL sb_owner done=%b expected %b", bif.req_done, want);
        end
        checks++;
        if (bif.req_rdata !== e.rdata) begin
          errors++;
          $display("FAIL sb_rdata got %h expected %h", bif.req_rdata, e.rdata);
        end
        checks++;
        if (bif.req_resp !== e.resp) begin
          errors++;
          $display("FAIL sb_resp got %b expected %b", bif.req_resp, e.resp);
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic set_req(input int i, input logic wr, input logic [31:0] a, input logic [31:0] d);
    bif.req_write[i]        = wr;
    bif.req_addr[i*32 +: 32]  = a;
    bif.req_wdata[i*32 +: 32] = d;
  endtask

  task automatic push_exp(input int owner, input logic [31:0] rd, input logic resp);
    exp_t e;
    e.owner = owner;
    e.rdata = rd;
    e.resp  = resp;
    exp_q.push_back(e);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bif.req_valid = '0;
    bif.req_write = '0;
    bif.req_addr = '0;
    bif.req_wdata = '0;
    bif.bus_read_data = '0;
    bif.bus_ready = 1'b0;
    bif.bus_response = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if ({bif.req_grant, bif.req_done, bif.bus_trans, bif.bus_write, bif.req_resp} !== '0) begin
      errors++;
      $display("FAIL reset_ctrl grant=%b done=%b trans=%b write=%b resp=%b expected all 0",
               bif.req_grant, bif.req_done, bif.bus_trans, bif.bus_write, bif.req_resp);
    end
    checks++;
    if ({bif.req_rdata, bif.bus_address, bif.bus_write_data} !== '0) begin
      errors++;
      $display("FAIL reset_data rdata=%h addr=%h wdata=%h expected 0",
               bif.req_rdata, bif.bus_address, bif.bus_write_data);
    end
    rst = 1'b0;
    model_rdata = '0;
  endtask

  task automatic test_single_read();
    set_req(0, 1'b0, 32'h0000_0100, 32'h0);
    bif.bus_ready = 1'b1;
    bif.bus_read_data = 32'hDEAD_BEEF;
    bif.req_valid = 3'b001;
    push_exp(0, 32'hDEAD_BEEF, RESP_OKAY);
    model_rdata = 32'hDEAD_BEEF;
    @(negedge clk);
    checks++;
    if (bif.bus_trans !== TRANS_NONSEQ || bif.req_grant !== 3'b001 ||
        bif.bus_address !== 32'h100 || bif.bus_write !== 1'b0) begin
      errors++;
      $display("FAIL single_addr_phase trans=%b grant=%b addr=%h write=%b expected 10 001 100 0",
               bif.bus_trans, bif.req_grant, bif.bus_address, bif.bus_write);
    end
    @(negedge clk);
    checks++;
    if (bif.bus_trans !== TRANS_IDLE || bif.req_done !== '0) begin
      errors++;
      $display("FAIL single_data_phase trans=%b done=%b expected 00 000", bif.bus_trans, bif.req_done);
    end
    @(negedge clk);
    checks++;
    if (bif.req_done !== 3'b001) begin
      errors++;
      $display("FAIL single_latency done=%b expected 001 three cycles after request", bif.req_done);
    end
    bif.req_valid = '0;
    @(negedge clk);
    checks++;
    if (bif.req_done !== '0 || bif.req_grant !== '0) begin
      errors++;
      $display("FAIL single_no_regrant done=%b grant=%b expected 000 000", bif.req_done, bif.req_grant);
    end
  endtask

  task automatic test_contention();
    int n;
    logic [N-1:0] want;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    model_rdata = '0;
    set_req(0, 1'b0, 32'h10, 32'h0);
    set_req(1, 1'b0, 32'h20, 32'h0);
    bif.bus_ready = 1'b1;
    bif.bus_read_data = 32'hC0DE_0000;
    for (int k = 0; k < 4; k++) push_exp(k % 2, 32'hC0DE_0000 + k, RESP_OKAY);
    model_rdata = 32'hC0DE_0003;
    bif.req_valid = 3'b011;
    for (int k = 0; k < 4; k++) begin
      n = 0;
      do begin @(negedge clk); n++; end while (bif.req_done == '0 && n < LIM);
      want = N'(1) << (k % 2);
      checks++;
      if (bif.req_done !== want || n != 3) begin
        errors++;
        $display("FAIL contention_order xfer=%0d done=%b after %0d cycles expected %b after 3",
                 k, bif.req_done, n, want);
      end
      bif.bus_read_data = 32'hC0DE_0000 + k + 1;
    end
    bif.req_valid = '0;
  endtask

  task automatic test_wait_write();
    set_req(1, 1'b1, 32'h0000_2000, 32'h1234_5678);
    bif.bus_ready = 1'b0;
    bif.bus_read_data = 32'hBAD0_BAD0;
    bif.bus_response = 1'b0;
    bif.req_valid = 3'b010;
    push_exp(1, model_rdata, RESP_OKAY);
    @(negedge clk);
    checks++;
    if (bif.bus_trans !== TRANS_NONSEQ || bif.bus_write !== 1'b1 || bif.bus_address !== 32'h2000) begin
      errors++;
      $display("FAIL write_addr_phase trans=%b write=%b addr=%h expected 10 1 2000",
               bif.bus_trans, bif.bus_write, bif.bus_address);
    end
    // Request fields change after being latched; the transfer must not notice.
    set_req(1, 1'b0, 32'hFFFF_FFF0, 32'h0);
    for (int i = 0; i <= WAITS; i++) begin
      @(negedge clk);
      checks++;
      if (bif.bus_write_data !== 32'h1234_5678 || bif.req_done !== '0 || bif.req_grant !== 3'b010) begin
        errors++;
        $display("FAIL write_wait_stable cycle=%0d wdata=%h done=%b grant=%b expected 12345678 000 010",
                 i, bif.bus_write_data, bif.req_done, bif.req_grant);
      end
    end
    bif.bus_ready = 1'b1;
    @(negedge clk);
    checks++;
    if (bif.req_done !== 3'b010) begin
      errors++;
      $display("FAIL write_done done=%b expected 010 after ready", bif.req_done);
    end
    bif.req_valid = '0;
  endtask

  task automatic test_error();
    int n;
    set_req(0, 1'b0, 32'h300, 32'h0);
    bif.bus_ready = 1'b1;
    bif.bus_response = 1'b1;
    bif.bus_read_data = 32'h1111_2222;
    push_exp(0, 32'h1111_2222, RESP_ERROR);
    bif.req_valid = 3'b001;
    n = 0;
    do begin @(negedge clk); n++; end while (bif.req_done == '0 && n < LIM);
    checks++;
    if (bif.req_resp !== 1'b1) begin
      errors++;
      $display("FAIL error_resp resp=%b expected 1", bif.req_resp);
    end
    bif.req_valid = '0;
    bif.bus_response = 1'b0;
    @(negedge clk);
    set_req(0, 1'b0, 32'h304, 32'h0);
    bif.bus_read_data = 32'h3333_4444;
    push_exp(0, 32'h3333_4444, RESP_OKAY);
    model_rdata = 32'h3333_4444;
    bif.req_valid = 3'b001;
    n = 0;
    do begin @(negedge clk); n++; end while (bif.req_done == '0 && n < LIM);
    checks++;
    if (bif.req_done !== 3'b001 || bif.req_resp !== 1'b0) begin
      errors++;
      $display("FAIL error_next_xfer done=%b resp=%b expected 001 0", bif.req_done, bif.req_resp);
    end
    bif.req_valid = '0;
  endtask

  task automatic test_reset_mid_data();
    int n;
    set_req(1, 1'b0, 32'h400, 32'h0);
    bif.bus_ready = 1'b0;
    bif.req_valid = 3'b010;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    bif.req_valid = '0;
    @(negedge clk);
    rst = 1'b0;
    model_rdata = '0;
    checks++;
    if ({bif.req_grant, bif.req_done, bif.bus_trans, bif.bus_write, bif.req_resp} !== '0 ||
        {bif.req_rdata, bif.bus_address, bif.bus_write_data} !== '0) begin
      errors++;
      $display("FAIL midreset_outputs grant=%b done=%b trans=%b rdata=%h addr=%h expected all 0",
               bif.req_grant, bif.req_done, bif.bus_trans, bif.req_rdata, bif.bus_address);
    end
    set_req(0, 1'b0, 32'h500, 32'h0);
    set_req(1, 1'b0, 32'h600, 32'h0);
    bif.bus_ready = 1'b1;
    bif.bus_read_data = 32'h5555_AAAA;
    push_exp(0, 32'h5555_AAAA, RESP_OKAY);
    push_exp(1, 32'h5555_AAAA, RESP_OKAY);
    model_rdata = 32'h5555_AAAA;
    bif.req_valid = 3'b011;
    @(negedge clk);
    checks++;
    if (bif.req_grant !== 3'b001) begin
      errors++;
      $display("FAIL midreset_first_grant grant=%b expected 001", bif.req_grant);
    end
    for (int k = 0; k < 2; k++) begin
      n = 0;
      do begin @(negedge clk); n++; end while (bif.req_done == '0 && n < LIM);
      checks++;
      if (bif.req_done == '0) begin
        errors++;
        $display("FAIL midreset_done_timeout xfer=%0d done=%b expected a completion", k, bif.req_done);
      end
    end
    bif.req_valid = '0;
  endtask

  task automatic test_rotation();
    int n;
    int owner;
    logic [N-1:0] want;
    // The previous scenario finished with requester 1, so rotation starts at 2.
    for (int i = 0; i < N; i++) set_req(i, 1'b0, 32'h800 + 32'(i * 4), 32'h0);
    bif.bus_ready = 1'b1;
    bif.bus_read_data = 32'hA0A0_0000;
    for (int k = 0; k < 6; k++) push_exp((2 + k) % N, 32'hA0A0_0000 + k, RESP_OKAY);
    model_rdata = 32'hA0A0_0005;
    bif.req_valid = 3'b111;
    for (int k = 0; k < 6; k++) begin
      owner = (2 + k) % N;
      want  = N'(1) << owner;
      n = 0;
      do begin @(negedge clk); n++; end while (bif.req_done == '0 && n < LIM);
      checks++;
      if (bif.req_done !== want) begin
        errors++;
        $display("FAIL rotation_order xfer=%0d done=%b expected %b", k, bif.req_done, want);
      end
      bif.bus_read_data = 32'hA0A0_0000 + k + 1;
    end
    bif.req_valid = '0;
    @(negedge clk);
  endtask

`ifdef BUS_ARB_TIMEOUT_EN
  task automatic test_timeout();
    int n;
    set_req(0, 1'b0, 32'h700, 32'h0);
    bif.bus_ready = 1'b0;
    bif.bus_response = 1'b0;
    bif.bus_read_data = 32'h7777_7777;
    push_exp(0, 32'h0, RESP_ERROR);
    model_rdata = '0;
    bif.req_valid = 3'b001;
    n = 0;
    do begin @(negedge clk); n++; end while (bif.req_done == '0 && n < LIM);
    checks++;
    if (bif.req_done !== 3'b001 || n != TO + 2) begin
      errors++;
      $display("FAIL timeout_fire done=%b after %0d cycles expected 001 after %0d",
               bif.req_done, n, TO + 2);
    end
    bif.req_valid = '0;
    @(negedge clk);
    push_exp(0, 32'h7777_7777, RESP_OKAY);
    model_rdata = 32'h7777_7777;
    bif.req_valid = 3'b001;
    repeat (TO + 1) @(negedge clk);
    bif.bus_ready = 1'b1;
    @(negedge clk);
    checks++;
    if (bif.req_done !== 3'b001 || bif.req_resp !== 1'b0) begin
      errors++;
      $display("FAIL timeout_ready_wins done=%b resp=%b expected 001 0", bif.req_done, bif.req_resp);
    end
    bif.req_valid = '0;
    @(negedge clk);
  endtask
`endif

  initial begin
    test_reset();
    test_single_read();
    test_contention();
    test_wait_write();
    test_error();
    test_reset_mid_data();
    test_rotation();
`ifdef BUS_ARB_TIMEOUT_EN
    test_timeout();
`endif
    repeat (3) @(negedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL sb_drain outstanding=%0d expected 0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/bus_arbiter.md
Name: bus_arbiter

Overview:
- Shares the single bus master port between N requesters (fetch unit, load/store unit, debug) using round-robin arbitration.
- Sits between the core-side requesters and the bus controller's master interface.
- Sequences each request as one AHB-style single transfer: NONSEQ address phase, then a data phase that waits on ready.
- Returns read data and response to the granted requester with a one-cycle done pulse.

Parameters:
- N_REQ, 2, number of requesters (2..8); requester 0 wins ties after reset.
- TIMEOUT_CYCLES, 64, data-phase watchdog limit; used only with the optional feature.

Ports:
- clk  input  1  system clock, all state on rising edge
- rst  input  1  synchronous, active-high reset
- req_valid  input  N_REQ  per-requester request, held until its done
- req_write  input  N_REQ  1=write, 0=read
- req_addr  input  N_REQ*32  per-requester address, slice i = [32*i+31:32*i]
- req_wdata  input  N_REQ*32  per-requester write data
- req_grant  output  N_REQ  one-hot, high from address phase until done
- req_done  output  N_REQ  one-cycle pulse to the owner on completion
- req_rdata  output  32  captured read data, valid with req_done
- req_resp  output  1  captured transfer_response, valid with req_done
- bus_trans  output  2  transfer_kind to bus master
- bus_write  output  1  bus write
- bus_address  output  32  bus address
- bus_write_data  output  32  bus write data, data phase
- bus_read_data  input  32  bus read data
- bus_ready  input  1  bus ready
- bus_response  input  1  bus transfer_response

Behaviour:
- Reset (rst=1 at a clk edge): state=IDLE; last_owner=N_REQ-1, so requester 0 has top priority; req_grant=0; req_done=0; req_rdata=0; req_resp=RESP_OKAY; bus_trans=IDLE; bus_write=0; bus_address=0; bus_write_data=0.
- Reset mid-transfer aborts silently: no done pulse, all outputs return to reset values next cycle.
- IDLE:
  - If any req_valid is set, pick the first set bit searching from last_owner+1 modulo N_REQ.
  - Latch owner, write, addr and wdata into registers.
  - Go to ADDR; req_grant becomes one-hot on the owner.
  - If no request, stay in IDLE with bus_trans=IDLE.
- ADDR (exactly 1 cycle): bus_trans=NONSEQ, bus_address and bus_write come from the latched values; go to DATA.
- DATA:
  - bus_trans=IDLE; bus_write_data = latched wdata, held stable.
  - On bus_ready=1: capture bus_read_data into req_rdata (reads only; writes leave req_rdata unchanged) and bus_response into req_resp.
  - In the same cycle, pulse req_done[owner], set last_owner=owner, clear grant, go to IDLE.
- Latency: req_valid seen in IDLE → done at least 3 cycles later (IDLE, ADDR, DATA with ready=1); each extra wait cycle adds 1.
- Back-to-back transfers:
  - A requester that drops req_valid the cycle after done is not re-granted.
  - A requester that keeps req_valid asserted is re-arbitrated in IDLE, and round-robin ensures any other pending requester wins.
- Changes to req_* inputs after latching are ignored until the next IDLE.
- An error response is passed through unchanged; no retry.
- Simultaneous requests from all N_REQ requesters are served in strict rotation, so no requester waits more than N_REQ-1 transfers.

Optional Feature:
- Macro: BUS_ARB_TIMEOUT_EN
- Defined:
  - A counter of width $clog2(TIMEOUT_CYCLES+1) clears on entry to DATA and increments each DATA cycle with bus_ready=0.
  - When it reaches TIMEOUT_CYCLES, the transfer completes with req_resp=RESP_ERROR and req_rdata=0, done pulses, state goes to IDLE.
  - bus_ready arriving on the same cycle as the timeout wins: normal completion.
- Undefined: no counter; DATA waits for bus_ready indefinitely.

Decomposition:
- Shared package holds:
  - transfer_kind and transfer_response (moved out of the bus file).
  - arb_state enum {ARB_IDLE, ARB_ADDR, ARB_DATA}.
  - ARB_N_REQ default constant.
- Sub-module rr_picker: combinational. Inputs are the request vector and last_owner; outputs are the winner index and a valid flag.

Test Plan:
- Single read: req0 with addr 0x100; bus_ready=1 at the first DATA cycle and bus_read_data=0xDEADBEEF → bus_trans=NONSEQ exactly 1 cycle, req_done[0] 3 cycles after request, req_rdata=0xDEADBEEF, resp=OKAY.
- Contention: req0 and req1 held continuously for 4 transfers → grant order 0,1,0,1 and done pulses alternate.
- Wait states on a write: req1 writes 0x12345678 to 0x2000; bus_ready low for 5 cycles → bus_write_data stable all 5 cycles, done on the cycle ready rises, req_rdata unchanged.
- Error passthrough: bus_response=ERROR with ready=1 → req_resp=1 on done; the next transfer is unaffected.
- Reset mid-DATA: rst asserted for 1 cycle during a wait → no done pulse, all outputs at reset values, next grant goes to requester 0.
- BUS_ARB_TIMEOUT_EN with TIMEOUT_CYCLES=4 and ready held low → done after 4 DATA cycles with resp=ERROR and rdata=0; a second run with ready rising on cycle 4 gives OKAY.
